// File: rtl/bbox_overlay.sv
// Double-buffered bounding-box store plus a 2-cycle outline overlay on the video stream.
// Define BBOX_OVERLAY_DEDUP_EN to drop near-duplicate boxes during capture.
module bbox_overlay #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int MAX_BOXES    = 8,
    parameter int LINE_WIDTH   = 2,
    parameter int COORD_WIDTH  = 16,
    parameter int DEDUP_DIST   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   de,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic [7:0]             r,
    input  logic [7:0]             g,
    input  logic [7:0]             b,
    input  logic                   bbox_valid,
    input  logic [COORD_WIDTH-1:0] bbox_x_start,
    input  logic [COORD_WIDTH-1:0] bbox_y_start,
    input  logic [COORD_WIDTH-1:0] bbox_x_end,
    input  logic [COORD_WIDTH-1:0] bbox_y_end,
    input  logic                   done,
    input  logic                   overlay_en,
    input  logic [23:0]            box_color,
    output logic                   de_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [7:0]             r_out,
    output logic [7:0]             g_out,
    output logic [7:0]             b_out,
    output logic [4:0]             box_count,
    output logic                   overflow
);
    localparam int              CW      = COORD_WIDTH;
    localparam int              IDXW    = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;
    localparam logic [4:0]      MAX_CNT = 5'(MAX_BOXES);
    localparam logic [CW-1:0]   X_MAX   = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0]   Y_MAX   = CW'(IMAGE_HEIGHT - 1);
    localparam logic [CW:0]     LW      = (CW+1)'(LINE_WIDTH);

    typedef struct packed {
        logic [CW-1:0] xs;
        logic [CW-1:0] ys;
        logic [CW-1:0] xe;
        logic [CW-1:0] ye;
    } box_t;

    typedef enum logic {COLLECT, PENDING} state_t;

    if (MAX_BOXES < 1 || MAX_BOXES > 16 || LINE_WIDTH < 1 || LINE_WIDTH > 8 || DEDUP_DIST < 0) begin : g_param_err
        $error("bbox_overlay: parameter out of range");
    end

    state_t            state;
    logic              front;
    logic              back;
    logic [4:0]        cnt [2];
    logic              ovf [2];
    box_t              bank [2][MAX_BOXES];
    box_t              in_box;

    logic [CW-1:0]     x_cnt;
    logic [CW-1:0]     y_cnt;

    logic [2:1]        vld_pipe;
    logic [2:1]        hs_pipe;
    logic [2:1]        vs_pipe;
    logic [23:0]       rgb_s1;
    logic [23:0]       rgb_s2;
    logic [23:0]       col_s1;
    logic              ovl_s1;
    logic [MAX_BOXES-1:0] hit;
    logic [MAX_BOXES-1:0] hit_s1;

    logic              vs_rise;
    logic              de_fall;
    logic              swap;
    logic              store;
    logic              drop;
    logic              dup;
    logic              wr_bank;
    logic [IDXW-1:0]   wr_idx;

    assign back    = ~front;
    assign in_box  = {bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end};
    // stage-1 registers double as the previous-cycle copy of the timing inputs
    assign vs_rise = vsync & ~vs_pipe[1];
    assign de_fall = vld_pipe[1] & ~de;

`ifdef BBOX_OVERLAY_DEDUP_EN
    localparam logic [CW-1:0] DD = CW'(DEDUP_DIST);

    function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] c);
        return (a >= c) ? a - c : c - a;
    endfunction

    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < MAX_BOXES; k++) begin
            if (5'(k) < cnt[back] &&
                absdiff(bank[back][k].xs, bbox_x_start) <= DD &&
                absdiff(bank[back][k].ys, bbox_y_start) <= DD)
                dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Capture decode; in the swap cycle the incoming box lands in slot 0 of the old front bank.
    always_comb begin
        swap    = (state == PENDING) && vs_rise;
        store   = 1'b0;
        drop    = 1'b0;
        wr_bank = back;
        wr_idx  = cnt[back][IDXW-1:0];
        if (swap) begin
            wr_bank = front;
            wr_idx  = '0;
            store   = bbox_valid;
        end else if (bbox_valid) begin
            if (state == PENDING) begin
                drop = 1'b1;
            end else if (!dup) begin
                if (cnt[back] < MAX_CNT) store = 1'b1;
                else                     drop  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) bank[wr_bank][wr_idx] <= in_box;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            front     <= 1'b0;
            cnt[0]    <= '0;
            cnt[1]    <= '0;
            ovf[0]    <= 1'b0;
            ovf[1]    <= 1'b0;
            box_count <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (store) cnt[back] <= cnt[back] + 5'd1;
                    if (drop)  ovf[back] <= 1'b1;
                    if (done)  state     <= PENDING;
                end
                PENDING: begin
                    if (swap) begin
                        front      <= back;
                        box_count  <= cnt[back];
                        overflow   <= ovf[back];
                        cnt[front] <= {4'd0, store};
                        ovf[front] <= 1'b0;
                        state      <= COLLECT;
                    end else if (drop) begin
                        ovf[back]  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (vs_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (de_fall) begin
            x_cnt <= '0;
            if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
        end else if (de && x_cnt != X_MAX) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    // Per-box outline test; differences are taken only inside the box so they never go negative.
    for (genvar k = 0; k < MAX_BOXES; k++) begin : g_box
        box_t bx;
        logic in_x, in_y, on_edge;
        assign bx      = bank[front][k];
        assign in_x    = (x_cnt >= bx.xs) && (x_cnt <= bx.xe);
        assign in_y    = (y_cnt >= bx.ys) && (y_cnt <= bx.ye);
        assign on_edge = (({1'b0, x_cnt} - {1'b0, bx.xs}) < LW) ||
                         (({1'b0, bx.xe} - {1'b0, x_cnt}) < LW) ||
                         (({1'b0, y_cnt} - {1'b0, bx.ys}) < LW) ||
                         (({1'b0, bx.ye} - {1'b0, y_cnt}) < LW);
        assign hit[k]  = (5'(k) < cnt[front]) && in_x && in_y && on_edge;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            rgb_s1   <= '0;
            rgb_s2   <= '0;
            col_s1   <= '0;
            ovl_s1   <= 1'b0;
            hit_s1   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], de};
            hs_pipe  <= {hs_pipe[1], hsync};
            vs_pipe  <= {vs_pipe[1], vsync};
            rgb_s1   <= {r, g, b};
            col_s1   <= box_color;
            ovl_s1   <= overlay_en;
            hit_s1   <= hit;
            rgb_s2   <= (vld_pipe[1] && ovl_s1 && |hit_s1) ? col_s1 : rgb_s1;
        end
    end

    assign de_out    = vld_pipe[2];
    assign hsync_out = hs_pipe[2];
    assign vsync_out = vs_pipe[2];
    assign r_out     = rgb_s2[23:16];
    assign g_out     = rgb_s2[15:8];
    assign b_out     = rgb_s2[7:0];

endmodule
